// File: rtl/serial_tx_param_pkg.sv
// Shared types and helpers for the serial status transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_e;

  localparam int unsigned MAX_WIDTH = 32;
  // Bit-counter width for the widest supported frame.
  localparam int unsigned CNT_W     = $clog2(MAX_WIDTH + 1);

  // Zero-extended words do not change the XOR, so one width serves every WIDTH.
  function automatic logic par_calc(input logic [MAX_WIDTH-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/serial_tx_param_if.sv
// Source-side handshake and serial-link signals of the transmitter.
interface serial_tx_param_if #(
  parameter int unsigned WIDTH = 4
);

  logic             init;
  logic [WIDTH-1:0] data;
  logic             status_send;
  logic             status_out;
  logic             busy;
  logic             pend_full;
  logic             done;
  logic             overrun;

  modport master (
    output init, data,
    input  status_send, status_out, busy, pend_full, done, overrun
  );

  modport slave (
    input  init, data,
    output status_send, status_out, busy, pend_full, done, overrun
  );

endinterface

// File: rtl/serial_tx_param_pend_buf.sv
// One-deep pending word register with full flag; push and pop may coincide.
module serial_pend_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             full_q, full_d;

  always_comb begin
    word_d = word_q;
    full_d = full_q;
    if (push_i) begin
      word_d = data_i;
      full_d = 1'b1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      word_q <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      full_q <= full_d;
    end
  end

  assign data_o = word_q;
  assign full_o = full_q;

endmodule

// File: rtl/serial_tx_param.sv
// Parametrised one-wire frame serializer with optional parity and a one-deep pending buffer.
module serial_tx_param
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_tx_param_if.slave  bus
);

  localparam int unsigned         CNT_BITS = $clog2(WIDTH + 1);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                par_q, par_d;
  logic                send_q, send_d;
  logic                out_q, out_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic                idle, frame_end, start, push, pop, pend_full;
  logic [WIDTH-1:0]    pend_word, start_word;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // cnt_q counts data bits still to come after the one currently on the line.
  assign idle       = (state_q == IDLE);
  assign frame_end  = ((state_q == DATA) && (cnt_q == '0) && (PARITY_EN == 0)) ||
                      (state_q == PAR);
  assign start      = idle ? bus.init : (frame_end && (pend_full || bus.init));
  assign pop        = frame_end && pend_full;
  assign start_word = pop ? pend_word : bus.data;
  // At a frame end a full buffer is drained, so the incoming word always fits.
  assign push       = bus.init && !idle && (pend_full ? frame_end : !frame_end);
  assign ovr_d      = bus.init && !idle && pend_full && !frame_end;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    send_d  = send_q;
    out_d   = 1'b0;
    done_d  = 1'b0;
    if (start) begin
      state_d = DATA;
      cnt_d   = LAST_CNT;
      par_d   = par_calc(MAX_WIDTH'(start_word), PARITY_ODD != 0);
      send_d  = 1'b1;
      out_d   = head(start_word);
      shreg_d = advance(start_word);
    end else begin
      case (state_q)
        DATA: begin
          if (cnt_q != '0) begin
            out_d   = head(shreg_q);
            shreg_d = advance(shreg_q);
            cnt_d   = cnt_q - 1'b1;
            done_d  = (cnt_q == CNT_BITS'(1)) && (PARITY_EN == 0);
          end else if (PARITY_EN != 0) begin
            state_d = PAR;
            out_d   = par_q;
            done_d  = 1'b1;
          end else begin
            state_d = IDLE;
            send_d  = 1'b0;
          end
        end
        PAR: begin
          state_d = IDLE;
          send_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      send_q  <= 1'b0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      send_q  <= send_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  serial_pend_buf #(
    .WIDTH (WIDTH)
  ) u_pend (
    .clk     (clk),
    .clear_i (!rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.data),
    .data_o  (pend_word),
    .full_o  (pend_full)
  );

  assign bus.status_send = send_q;
  assign bus.busy        = send_q;
  assign bus.status_out  = out_q;
  assign bus.done        = done_q;
  assign bus.overrun     = ovr_q;
  assign bus.pend_full   = pend_full;

endmodule

// File: tb/tb_serial_tx_param.sv
// Scoreboard bench: stimulus queues hand-computed serial bits, per-DUT monitors pop and compare.
module tb_serial_tx_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_tx_param_if #(.WIDTH(4)) if_a ();
  serial_tx_param_if #(.WIDTH(4)) if_b ();
  serial_tx_param_if #(.WIDTH(4)) if_c ();
  serial_tx_param_if #(.WIDTH(8)) if_d ();

  serial_tx_param #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  serial_tx_param #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  serial_tx_param #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  serial_tx_param #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Entry = {must follow a sending cycle, done expected, data bit}
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] q2[$];
  logic [2:0] q3[$];
  logic [3:0] prev_send = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bits holds the frame in line order, first bit at bits[n-1].
  task automatic push_bits(input int id, input logic [31:0] bits, input int n,
                           input bit cont_first, input bit done_last);
    for (int i = n - 1; i >= 0; i--) begin
      logic [2:0] e;
      e = {(i == n - 1) ? cont_first : 1'b1, (i == 0) ? done_last : 1'b0, bits[i]};
      case (id)
        0: q0.push_back(e);
        1: q1.push_back(e);
        2: q2.push_back(e);
        default: q3.push_back(e);
      endcase
    end
  endtask

  task automatic mon(input int id, input logic s, input logic o, input logic b, input logic d);
    logic [2:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    checks++;
    if (s) begin
      case (id)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        errors++;
        $display("FAIL mon%0d_unexpected: got bit %0b expected no frame", id, o);
      end else if (o !== e[0] || d !== e[1] || b !== 1'b1 || (e[2] && !prev_send[id])) begin
        errors++;
        $display("FAIL mon%0d_bit: got bit=%0b done=%0b busy=%0b prev_send=%0b expected bit=%0b done=%0b busy=1 contiguous=%0b",
                 id, o, d, b, prev_send[id], e[0], e[1], e[2]);
      end
    end else if (o !== 1'b0 || d !== 1'b0 || b !== 1'b0) begin
      errors++;
      $display("FAIL mon%0d_idle: got out=%0b done=%0b busy=%0b expected 0 0 0", id, o, d, b);
    end
    prev_send[id] = s;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, if_a.status_send, if_a.status_out, if_a.busy, if_a.done);
      mon(1, if_b.status_send, if_b.status_out, if_b.busy, if_b.done);
      mon(2, if_c.status_send, if_c.status_out, if_c.busy, if_c.done);
      mon(3, if_d.status_send, if_d.status_out, if_d.busy, if_d.done);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.init = 1'b0; if_a.data = '0;
    if_b.init = 1'b0; if_b.data = '0;
    if_c.init = 1'b0; if_c.data = '0;
    if_d.init = 1'b0; if_d.data = '0;
    cyc(3);
    check("rst_send_a", if_a.status_send, 0);
    check("rst_out_b", if_b.status_out, 0);
    check("rst_done_c", if_c.done, 0);
    check("rst_pend_d", if_d.pend_full, 0);
    check("rst_ovr_d", if_d.overrun, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // MSB first, 1011 -> 1,0,1,1
    if_a.init = 1'b1; if_a.data = 4'b1011;
    push_bits(0, 32'b1011, 4, 1'b0, 1'b1);
    cyc(1);
    if_a.init = 1'b0;
    check("t1_first_send", if_a.status_send, 1);
    check("t1_first_bit", if_a.status_out, 1);
    cyc(6);

    // LSB first 1011 -> 1,1,0,1; with odd parity a fifth bit 0
    if_b.init = 1'b1; if_b.data = 4'b1011;
    if_c.init = 1'b1; if_c.data = 4'b1011;
    push_bits(1, 32'b1101, 4, 1'b0, 1'b1);
    push_bits(2, 32'b11010, 5, 1'b0, 1'b1);
    cyc(1);
    if_b.init = 1'b0;
    if_c.init = 1'b0;
    cyc(7);

    // A5 then 3C queued behind it: 16 contiguous bits
    if_d.init = 1'b1; if_d.data = 8'hA5;
    push_bits(3, 32'hA5, 8, 1'b0, 1'b1);
    push_bits(3, 32'h3C, 8, 1'b1, 1'b1);
    cyc(1);
    if_d.init = 1'b0;
    cyc(1);
    if_d.init = 1'b1; if_d.data = 8'h3C;
    cyc(1);
    if_d.init = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("t3_pend_high", if_d.pend_full, 1);
      cyc(1);
    end
    check("t3_pend_clear", if_d.pend_full, 0);
    check("t3_no_ovr", if_d.overrun, 0);
    cyc(10);

    // Third init while buffer full is dropped with an overrun pulse
    if_d.init = 1'b1; if_d.data = 8'hA5;
    push_bits(3, 32'hA5, 8, 1'b0, 1'b1);
    push_bits(3, 32'h3C, 8, 1'b1, 1'b1);
    cyc(1);
    if_d.data = 8'h3C;
    cyc(1);
    if_d.data = 8'hFF;
    cyc(1);
    if_d.init = 1'b0;
    check("t4_ovr_pulse", if_d.overrun, 1);
    check("t4_pend_full", if_d.pend_full, 1);
    cyc(1);
    check("t4_ovr_single", if_d.overrun, 0);
    cyc(20);
    check("t4_q_empty", q3.size(), 0);

    // Reset at bit 2 with a word pending: clean abort, no done
    if_a.init = 1'b1; if_a.data = 4'b1011;
    push_bits(0, 32'b10, 2, 1'b0, 1'b0);
    cyc(1);
    if_a.data = 4'b0110;
    cyc(1);
    if_a.init = 1'b0;
    check("t5_pend_before", if_a.pend_full, 1);
    rst_n = 1'b0;
    cyc(1);
    check("t5_send", if_a.status_send, 0);
    check("t5_out", if_a.status_out, 0);
    check("t5_done", if_a.done, 0);
    check("t5_pend", if_a.pend_full, 0);
    check("t5_busy", if_a.busy, 0);
    rst_n = 1'b1;
    cyc(2);
    if_a.init = 1'b1; if_a.data = 4'b0110;
    push_bits(0, 32'b0110, 4, 1'b0, 1'b1);
    cyc(1);
    if_a.init = 1'b0;
    cyc(6);

    // init on the frame-end edge with an empty buffer starts the next frame at once
    if_a.init = 1'b1; if_a.data = 4'b1001;
    push_bits(0, 32'b1001, 4, 1'b0, 1'b1);
    push_bits(0, 32'b0110, 4, 1'b1, 1'b1);
    cyc(1);
    if_a.init = 1'b0;
    cyc(3);
    if_a.init = 1'b1; if_a.data = 4'b0110;
    cyc(1);
    if_a.init = 1'b0;
    check("t6_pend_empty", if_a.pend_full, 0);
    check("t6_no_ovr", if_a.overrun, 0);
    cyc(6);

    // init held for 12 edges: four back-to-back frames
    if_a.init = 1'b1; if_a.data = 4'b1100;
    push_bits(0, 32'b1100, 4, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) push_bits(0, 32'b1100, 4, 1'b1, 1'b1);
    cyc(12);
    if_a.init = 1'b0;
    cyc(14);

    check("end_q0", q0.size(), 0);
    check("end_q1", q1.size(), 0);
    check("end_q2", q2.size(), 0);
    check("end_q3", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
